// File: rtl/jamma_pkg.sv
// rtl/jamma_pkg.sv - shared constants and types for the JAMMA input conditioner
package jamma_pkg;

    localparam int BTNS = 8;

    localparam int BTN_RGT   = 0;
    localparam int BTN_START = 1;
    localparam int BTN_S1    = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_S2    = 4;
    localparam int BTN_DN    = 5;
    localparam int BTN_S3    = 6;
    localparam int BTN_LFT   = 7;

    // 5 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_t;

endpackage

// File: rtl/jamma_debounce.sv
// rtl/jamma_debounce.sv - one JAMMA line: synchroniser, debounce FSM, edge pulses, sticky latch
module jamma_debounce
    import jamma_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    input  logic clr,
    output logic level,
    output logic press,
    output logic released,
    output logic latch,
    output logic press_nxt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_line;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_d, press_d, rel_d, latch_d;

    assign sync_line = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
            latch    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ~raw_n};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level    <= level_d;
            press    <= press_d;
            released <= rel_d;
            latch    <= latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync_line != level) begin
                    state_d = ST_COUNTING;
                    cnt_d   = CW'(1);
                end
            end
            ST_COUNTING: begin
                if (sync_line == level) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    level_d = ~level;
                    press_d = ~level;
                    rel_d   = level;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
        // A clear landing while the press pulse is still visible loses to the set
        latch_d = press_d | press | (latch & ~clr);
    end

    assign press_nxt = press_d;

endmodule

// File: rtl/jamma_input_ctrl.sv
// rtl/jamma_input_ctrl.sv - multi-player JAMMA input conditioner; JAMMA_LED_DEBUG_EN adds sw/Led panel checkout
module jamma_input_ctrl #(
    parameter int NUM_PLAYERS     = 2,
    parameter int BTNS            = jamma_pkg::BTNS,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = jamma_pkg::DEBOUNCE_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PLAYERS*BTNS-1:0] jamma_n,
    output logic [NUM_PLAYERS*BTNS-1:0] btn_level,
    output logic [NUM_PLAYERS*BTNS-1:0] btn_press,
    output logic [NUM_PLAYERS*BTNS-1:0] btn_release,
    output logic [NUM_PLAYERS*BTNS-1:0] press_latch,
    input  logic [NUM_PLAYERS*BTNS-1:0] latch_clr,
`ifdef JAMMA_LED_DEBUG_EN
    input  logic [7:0]                  sw,
    output logic [7:0]                  Led,
`endif
    output logic                        any_press
);

    localparam int NL = NUM_PLAYERS * BTNS;

    logic [NL-1:0] press_nxt;

    for (genvar i = 0; i < NL; i++) begin : g_line
        jamma_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .raw_n    (jamma_n[i]),
            .clr      (latch_clr[i]),
            .level    (btn_level[i]),
            .press    (btn_press[i]),
            .released (btn_release[i]),
            .latch    (press_latch[i]),
            .press_nxt(press_nxt[i])
        );
    end

    // OR the next-state pulses so any_press lines up with btn_press
    always_ff @(posedge clk) begin
        if (rst) any_press <= 1'b0;
        else     any_press <= |press_nxt;
    end

`ifdef JAMMA_LED_DEBUG_EN
    logic [7:0] led_d;

    always_comb begin
        led_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (sw[2:0] == 3'(p)) led_d = 8'(btn_level[p*BTNS +: BTNS]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) Led <= '0;
        else     Led <= led_d;
    end
`endif

endmodule

// File: tb/tb_jamma_input_ctrl.sv
// tb/tb_jamma_input_ctrl.sv - directed self-checking bench for jamma_input_ctrl
module tb_jamma_input_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] jamma_n;
    logic [15:0] latch_clr;
    logic [15:0] btn_level, btn_press, btn_release, press_latch;
    logic        any_press;
`ifdef JAMMA_LED_DEBUG_EN
    logic [7:0]  sw;
    logic [7:0]  Led;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] acc;

    always #5 clk = ~clk;

    jamma_input_ctrl #(
        .NUM_PLAYERS    (2),
        .BTNS           (8),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .jamma_n    (jamma_n),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .press_latch(press_latch),
        .latch_clr  (latch_clr),
`ifdef JAMMA_LED_DEBUG_EN
        .sw         (sw),
        .Led        (Led),
`endif
        .any_press  (any_press)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        jamma_n   = 16'hFFFF;
        latch_clr = 16'h0000;
`ifdef JAMMA_LED_DEBUG_EN
        sw        = 8'd1;
`endif
        repeat (3) tick();
        check("rst_level", btn_level, 16'h0000);
        check("rst_press", btn_press, 16'h0000);
        check("rst_release", btn_release, 16'h0000);
        check("rst_latch", press_latch, 16'h0000);
        check("rst_any", {15'd0, any_press}, 16'h0000);
        rst = 1'b0;

        // idle for 20 cycles with all lines released
        acc = '0;
        repeat (20) begin
            tick();
            acc = acc | btn_press | btn_release | btn_level | press_latch;
        end
        check("idle_quiet", acc, 16'h0000);

        // P1 START pressed: accepted at edge 6
        jamma_n[1] = 1'b0;
        repeat (6) tick();                 // edges 0..5
        check("p1s_level_e5", btn_level, 16'h0000);
        check("p1s_press_e5", btn_press, 16'h0000);
        tick();                            // edge 6
        check("p1s_level_e6", btn_level, 16'h0002);
        check("p1s_press_e6", btn_press, 16'h0002);
        check("p1s_any_e6", {15'd0, any_press}, 16'h0001);
        check("p1s_latch_e6", press_latch, 16'h0002);
        latch_clr[1] = 1'b1;               // clear alongside the press pulse
        tick();                            // edge 7
        latch_clr[1] = 1'b0;
        check("p1s_press_e7", btn_press, 16'h0000);
        check("p1s_any_e7", {15'd0, any_press}, 16'h0000);
        check("latch_set_wins", press_latch, 16'h0002);
        tick();                            // edge 8
        check("latch_hold", press_latch, 16'h0002);
        latch_clr[1] = 1'b1;
        tick();                            // edge 9
        latch_clr[1] = 1'b0;
        check("latch_cleared", press_latch, 16'h0000);
        check("level_after_clr", btn_level, 16'h0002);

        // P2 UP glitch of 3 cycles is rejected
        jamma_n[11] = 1'b0;
        repeat (3) tick();
        jamma_n[11] = 1'b1;
        acc = '0;
        repeat (10) begin
            tick();
            acc = acc | ((btn_press | btn_release | btn_level) & 16'h0800);
        end
        check("glitch_reject", acc, 16'h0000);

        // release P1 START
        jamma_n[1] = 1'b1;
        repeat (6) tick();
        check("rel_level_e5", btn_level, 16'h0002);
        tick();
        check("rel_pulse_e6", btn_release, 16'h0002);
        check("rel_level_e6", btn_level, 16'h0000);
        check("rel_nopress", btn_press, 16'h0000);
        tick();
        check("rel_pulse_e7", btn_release, 16'h0000);

        // all 16 lines on the same edge
        jamma_n = 16'h0000;
        repeat (6) tick();
        check("all_press_e5", btn_press, 16'h0000);
        tick();
        check("all_press_e6", btn_press, 16'hFFFF);
        check("all_level_e6", btn_level, 16'hFFFF);
        check("all_latch_e6", press_latch, 16'hFFFF);
        check("all_any_e6", {15'd0, any_press}, 16'h0001);
        tick();
        check("all_press_e7", btn_press, 16'h0000);
`ifdef JAMMA_LED_DEBUG_EN
        check("led_p2", {8'd0, Led}, 16'h00FF);
        sw = 8'd2;
        tick();
        tick();
        check("led_oob", {8'd0, Led}, 16'h0000);
        sw = 8'd1;
`endif
        jamma_n = 16'hFFFF;
        repeat (7) tick();
        check("all_release_e6", btn_release, 16'hFFFF);
        check("all_release_level", btn_level, 16'h0000);
        latch_clr = 16'hFFFF;
        tick();
        latch_clr = 16'h0000;
        check("all_latch_clr", press_latch, 16'h0000);

        // reset in the middle of a pending press
        jamma_n[1] = 1'b0;
        repeat (4) tick();                 // edges 0..3
        rst = 1'b1;
        tick();                            // edge 4 in reset
        rst = 1'b0;
        check("midrst_level", btn_level, 16'h0000);
        acc = '0;
        repeat (6) begin
            tick();
            acc = acc | btn_press | btn_level;
        end
        check("midrst_no_early", acc, 16'h0000);
        tick();
        check("midrst_press", btn_press, 16'h0002);
        check("midrst_level_up", btn_level, 16'h0002);
        check("midrst_latch", press_latch, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
